iter_mul: RTL and testbench
===========================

ITER_MUL -- requirements
Module: iter_mul

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are even and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port mode, input, 2 bits: 00 MUL (low half only), 01 UMULL, 10 SMULL, 11 reserved and executed as UMULL.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the multiplicand and the multiplier.
REQ-007 The block SHALL have port acc, input, 2*WIDTH bits: the accumulate addend; this port is present only when ITER_MUL_ACCUM_EN is defined.
REQ-008 The block SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-010 The block SHALL have ports result_lo and result_hi, output, WIDTH bits each: the registered product.
REQ-011 The block SHALL have port flags, output, 2 bits: {N,Z} of the final result.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and FIX: IDLE->RUN on start=1; RUN->FIX after WIDTH iterations; FIX->IDLE unconditionally.
REQ-013 start SHALL be accepted only in IDLE; start in RUN or FIX SHALL be ignored, with no queuing.
REQ-014 a, b, mode (and acc) SHALL be captured on the accept edge; later input changes SHALL have no effect on the operation in flight.
REQ-015 RUN SHALL perform radix-2 shift-add, one multiplier bit per cycle, on operand magnitudes; the iteration counter SHALL count 0..WIDTH-1.
REQ-016 FIX SHALL apply the sign correction (SMULL: negate the 2*WIDTH result if the operand signs differ), add acc when ITER_MUL_ACCUM_EN is defined, and load the result registers.
REQ-017 done SHALL be high for exactly one cycle, WIDTH+2 rising edges after the accept edge, i.e. in the cycle after FIX.
REQ-018 busy SHALL be 1 from the accept edge until the edge that raises done, and 0 while done is 1.
REQ-019 SMULL SHALL be exact for all inputs, including most-negative times most-negative; UMULL SHALL treat both operands as unsigned.
REQ-020 In MUL mode, result_hi SHALL be 0 and result_lo SHALL be the low WIDTH bits of the product; signedness is irrelevant.
REQ-021 Long modes: N SHALL be result_hi[WIDTH-1] and Z SHALL be 1 iff all 2*WIDTH bits are 0; MUL mode: N SHALL be result_lo[WIDTH-1] and Z SHALL be 1 iff result_lo is 0.
REQ-022 result_lo, result_hi and flags SHALL hold their values from done until the next FIX, and SHALL be unchanged during RUN.
REQ-023 start asserted in the same cycle done is high SHALL be accepted, because the FSM is in IDLE.

Reset
REQ-024 reset=0 at a clock edge SHALL force IDLE and set busy=0, done=0, result_lo=0, result_hi=0, flags=0 and counter=0.
REQ-025 Reset during RUN or FIX SHALL abort the operation: no done pulse and no result update.
REQ-026 start sampled while reset=0 SHALL be ignored.

Configuration
REQ-027 With ITER_MUL_ACCUM_EN defined, FIX SHALL add acc to the 2*WIDTH product modulo 2^(2*WIDTH) in all modes; MUL mode adds acc low half only.
REQ-028 Without ITER_MUL_ACCUM_EN, the acc port and adder SHALL be absent and results SHALL be the plain product; latency SHALL be identical in both builds.

Verification
REQ-029 WIDTH=32, UMULL, a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, N=1, Z=0, done exactly 34 edges after accept.
REQ-030 SMULL, a=0xFFFFFFFF (-1), b=0x00000002 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFFE, N=1.
REQ-031 SMULL, a=b=0x80000000 -> result_hi=0x40000000, result_lo=0x00000000, N=0, Z=0.
REQ-032 MUL, a=b=0x00010000 -> result_lo=0, result_hi=0, Z=1, N=0.
REQ-033 Start an op; pulse start again at cycle 5 -> ignored, with a single done; new op with reset=0 at cycle 10 -> busy=0, outputs=0, no done; start in a done cycle -> accepted.
REQ-034 ITER_MUL_ACCUM_EN defined: UMULL, a=3, b=4, acc=0xFFFFFFFF_FFFFFFFF -> result_hi=0, result_lo=0x0000000B.

Source files
------------

// File: rtl/iter_mul_if.sv
// Bus bundle for iter_mul: operation request, status and result signals.
// Carries the accumulate addend only when ITER_MUL_ACCUM_EN is defined.
interface iter_mul_if #(
    parameter int WIDTH = 32
);
    // Handshake: start is taken on a rising edge only while busy=0; done pulses
    // for one cycle when result_lo/result_hi/flags have just been loaded.
    logic               start;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
`ifdef ITER_MUL_ACCUM_EN
    logic [2*WIDTH-1:0] acc;
`endif
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result_lo;
    logic [WIDTH-1:0]   result_hi;
    logic [1:0]         flags;

`ifdef ITER_MUL_ACCUM_EN
    modport master (output start, mode, a, b, acc,
                    input  busy, done, result_lo, result_hi, flags);
    modport slave  (input  start, mode, a, b, acc,
                    output busy, done, result_lo, result_hi, flags);
`else
    modport master (output start, mode, a, b,
                    input  busy, done, result_lo, result_hi, flags);
    modport slave  (input  start, mode, a, b,
                    output busy, done, result_lo, result_hi, flags);
`endif
endinterface

// File: rtl/iter_mul.sv
// Iterative radix-2 shift-add multiplier (MUL/UMULL/SMULL), WIDTH+2 cycle latency.
// Optional accumulate of a 2*WIDTH addend in FIX when ITER_MUL_ACCUM_EN is defined.
module iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    iter_mul_if.slave  bus,
    output logic [1:0] o_dbg_state
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] MODE_MUL   = 2'b00;
    localparam logic [1:0] MODE_SMULL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_mode;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [1:0]         r_flags;
    logic               r_done;
`ifdef ITER_MUL_ACCUM_EN
    logic [2*WIDTH-1:0] r_acc;
`endif

    logic               w_smull;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_signed;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_fix_lo;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [1:0]         w_fix_flags;

    // Only SMULL works on magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    assign w_smull = (bus.mode == MODE_SMULL);
    assign w_mag_a = (w_smull && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_mag_b = (w_smull && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next   = RUN;
                    w_accept = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_is_mul = (r_mode == MODE_MUL);
        w_signed = r_neg ? (~r_prod + 1'b1) : r_prod;
`ifdef ITER_MUL_ACCUM_EN
        w_sum    = w_signed + r_acc;
`else
        w_sum    = w_signed;
`endif
        w_fix_lo = w_sum[WIDTH-1:0];
        w_fix_hi = w_is_mul ? '0 : w_sum[2*WIDTH-1:WIDTH];
        if (w_is_mul) begin
            w_fix_flags = {w_sum[WIDTH-1], (w_sum[WIDTH-1:0] == '0)};
        end else begin
            w_fix_flags = {w_sum[2*WIDTH-1], (w_sum == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_mode   <= '0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_flags  <= '0;
            r_done   <= 1'b0;
`ifdef ITER_MUL_ACCUM_EN
            r_acc    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_mode   <= bus.mode;
                        r_neg    <= w_smull & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                        r_mplier <= w_mag_b;
                        r_prod   <= '0;
`ifdef ITER_MUL_ACCUM_EN
                        r_acc    <= (bus.mode == MODE_MUL) ?
                                    {{WIDTH{1'b0}}, bus.acc[WIDTH-1:0]} : bus.acc;
`endif
                    end
                end
                RUN: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                FIX: begin
                    r_lo    <= w_fix_lo;
                    r_hi    <= w_fix_hi;
                    r_flags <= w_fix_flags;
                    r_done  <= 1'b1;
                    r_cnt   <= '0;
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = r_done;
    assign bus.result_lo = r_lo;
    assign bus.result_hi = r_hi;
    assign bus.flags     = r_flags;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_iter_mul.sv
// Scoreboard bench for iter_mul (WIDTH=32): directed vectors, monitor pops on done.
// Expected accumulate results switch with ITER_MUL_ACCUM_EN.
module tb_iter_mul;
    localparam int W  = 32;
    localparam int EW = 2 * W + 2;
    typedef logic [EW-1:0] ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;

    ev_t        exp_q[$];
    int         acc_q[$];
    string      name_q[$];

    iter_mul_if #(.WIDTH(W)) bus();

    iter_mul #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input ev_t act, input ev_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Result packed as {flags, result_hi, result_lo}.
    function automatic ev_t pack(input logic [1:0] f, input logic [W-1:0] hi, input logic [W-1:0] lo);
        return {f, hi, lo};
    endfunction

    // done is registered at edge accept+W+1, so it is high in the cycle sampled by edge accept+W+2.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d required no done", cyc);
            end else begin
                ev_t   e;
                int    t0;
                string nm;
                e  = exp_q.pop_front();
                t0 = acc_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_result"}, pack(bus.flags, bus.result_hi, bus.result_lo), e);
                check({nm, "_latency"}, ev_t'(cyc - t0), ev_t'(W + 1));
                check({nm, "_busy_at_done"}, ev_t'(bus.busy), ev_t'(0));
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the accept edge.
    task automatic issue(input string nm, input logic [1:0] m, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v, input logic [2*W-1:0] tacc,
                         input ev_t e, input bit push);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.a     = ta;
        bus.b     = tb_v;
`ifdef ITER_MUL_ACCUM_EN
        bus.acc   = tacc;
`else
        if (tacc != '0) $display("note: acc ignored in this build");
`endif
        if (push) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc + 1);
            name_q.push_back(nm);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.mode  = 2'($urandom_range(0, 3));
`ifdef ITER_MUL_ACCUM_EN
        bus.acc   = {$urandom, $urandom};
`endif
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: got busy=%b after 200 cycles required 0", bus.busy);
        end
    endtask

    task automatic run(input string nm, input logic [1:0] m, input logic [W-1:0] ta,
                       input logic [W-1:0] tb_v, input logic [2*W-1:0] tacc,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [1:0] f);
        issue(nm, m, ta, tb_v, tacc, pack(f, hi, lo), 1'b1);
        wait_idle();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
`ifdef ITER_MUL_ACCUM_EN
        bus.acc   = '0;
`endif
        // start held during reset must be ignored
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        repeat (2) @(negedge clk);
        check("reset_result", pack(bus.flags, bus.result_hi, bus.result_lo), '0);
        check("reset_ctl", ev_t'({bus.busy, bus.done, dbg_state}), '0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("idle_after_reset", ev_t'({bus.busy, dbg_state}), '0);

        run("umull_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 32'hFFFF_FFFE, 32'h0000_0001, 2'b10);
        run("smull_m1x2", 2'b10, 32'hFFFF_FFFF, 32'h0000_0002, '0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2'b10);
        run("smull_mneg", 2'b10, 32'h8000_0000, 32'h8000_0000, '0, 32'h4000_0000, 32'h0000_0000, 2'b00);
        run("mul_wrap0",  2'b00, 32'h0001_0000, 32'h0001_0000, '0, 32'h0000_0000, 32'h0000_0000, 2'b01);
        run("mul_ones",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 32'h0000_0000, 32'h0000_0001, 2'b00);
        run("mul_neg_n",  2'b00, 32'h0000_8000, 32'h0001_0000, '0, 32'h0000_0000, 32'h8000_0000, 2'b10);
        run("smull_7xm3", 2'b10, 32'h0000_0007, 32'hFFFF_FFFD, '0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 2'b10);
        run("smull_m5sq", 2'b10, 32'hFFFF_FFFB, 32'hFFFF_FFFB, '0, 32'h0000_0000, 32'h0000_0019, 2'b00);
        run("smull_mnx1", 2'b10, 32'h8000_0000, 32'h0000_0001, '0, 32'hFFFF_FFFF, 32'h8000_0000, 2'b10);
        run("rsvd_umull", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, '0, 32'h0000_0001, 32'hFFFF_FFFE, 2'b00);
        run("umull_zero", 2'b01, 32'h0000_0000, 32'h1234_5678, '0, 32'h0000_0000, 32'h0000_0000, 2'b01);
`ifdef ITER_MUL_ACCUM_EN
        run("umull_acc",  2'b01, 32'd3, 32'd4, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0000, 32'h0000_000B, 2'b00);
`else
        run("umull_3x4",  2'b01, 32'd3, 32'd4, '0, 32'h0000_0000, 32'h0000_000C, 2'b00);
`endif

        // start pulsed mid-run is dropped: one done, result stays from the first op
        issue("ign_base", 2'b01, 32'h10, 32'h10, '0, pack(2'b00, 32'h0, 32'h100), 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (W + 4) @(negedge clk);
        check("ign_hold", pack(bus.flags, bus.result_hi, bus.result_lo), pack(2'b00, 32'h0, 32'h100));

        // reset in RUN aborts: outputs cleared, no done afterwards
        issue("abort", 2'b01, 32'd7, 32'd7, '0, '0, 1'b0);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("abort_ctl", ev_t'({bus.busy, bus.done, dbg_state}), '0);
        check("abort_result", pack(bus.flags, bus.result_hi, bus.result_lo), '0);
        repeat (W + 4) @(negedge clk);
        check("abort_no_update", pack(bus.flags, bus.result_hi, bus.result_lo), '0);

        // start in the done cycle is accepted
        issue("dc_first", 2'b01, 32'd2, 32'd3, '0, pack(2'b00, 32'h0, 32'h6), 1'b1);
        begin
            int n = 0;
            while (bus.done !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("dc_done_seen", ev_t'(bus.done), ev_t'(1));
        end
        issue("dc_second", 2'b10, 32'hFFFF_FFFB, 32'h0000_0005, '0,
              pack(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFE7), 1'b1);
        check("dc_accepted", ev_t'(bus.busy), ev_t'(1));
        wait_idle();

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                n_vec++;
                n_err++;
                $display("FAIL drain: got %0d pending results required 0", exp_q.size());
            end
        end
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
